mdio_slave_fsm: RTL
===================

Name: mdio_slave_fsm

Overview:
- Parametrised PHY-side MDIO (Clause 22 frame) slave. Successor to the fixed 32-bit receiver.
- Decodes serial frames from the station manager, MSB-first: preamble, ST, OP, PHYAD, REGAD, TA, DATA.
- Filters frames by PHY address, with optional broadcast writes.
- Issues register-file write and read strobes, and serialises read data back onto MDIO_IN.
- Sits between the MDIO generator and the PHY register bank; clocked by MDC.

Parameters:
- PHY_ADDR, 5'd1, PHYAD this slave responds to.
- BCAST_EN, 1, when 1, write frames with PHYAD=0 are also accepted (reads never).
- PRE_LEN, 32, consecutive 1s required before ST; 0 = preamble suppression; range 0..63.
- REG_AW, 5, REGAD field width (ADDR width).
- DATA_W, 16, DATA field width (WR_DATA/RD_DATA width).
- STRICT_TA, 1, when 1, write-frame TA other than 2'b10 aborts with FRAME_ERR.

Ports:
- MDC  input  1  management clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low.
- MDIO_OE  input  1  station is driving the line; bits are sampled only when 1.
- MDIO_OUT  input  1  serial bit from the station.
- RD_DATA  input  DATA_W  register-bank read data; valid the cycle after RD_STB.
- MDIO_IN  output  1  serial bit driven to the station.
- MDIO_IN_EN  output  1  slave drives MDIO_IN.
- ADDR  output  REG_AW  register address of the current frame.
- WR_DATA  output  DATA_W  write data.
- WR_STB  output  1  one-cycle write strobe.
- RD_STB  output  1  one-cycle read request.
- MDIO_DONE  output  1  one-cycle frame-complete pulse.
- FRAME_ERR  output  1  one-cycle malformed-frame pulse.

Behaviour:
- Reset (rst=0 at MDC edge):
  - State IDLE; all counters 0.
  - All outputs 0, including ADDR and WR_DATA.
  - Reset overrides any in-progress frame: no strobe, no DONE, MDIO_IN_EN=0 next cycle.
- States and transitions:
  - IDLE/PRE: preamble counter increments on each sampled 1 (saturates at PRE_LEN). A sampled 0 with count==PRE_LEN -> ST. A sampled 0 with count<PRE_LEN clears the counter and stays.
  - ST: expects a sampled 1. Else FRAME_ERR, go to IDLE.
  - OP: two bits. 01 = write, 10 = read. 00/11 -> FRAME_ERR, IDLE.
  - PHYAD: 5 bits.
    - Match when PHYAD==PHY_ADDR, or (BCAST_EN && PHYAD==0 && op==write).
    - Mismatch -> SKIP.
  - REGAD: REG_AW bits. The edge sampling the last bit loads ADDR.
    - Read: RD_STB=1 at that same edge; go to RD_TA.
    - Write: go to WR_TA.
  - WR_TA: two bits sampled. If STRICT_TA and bits != 1,0 -> FRAME_ERR, IDLE.
  - WR_DATA: DATA_W bits shifted in MSB-first.
    - Edge sampling the last bit: WR_DATA loaded, WR_STB=1.
    - Next edge: WR_STB=0, MDIO_DONE=1.
    - Next edge: MDIO_DONE=0, IDLE.
  - RD_TA: MDIO_OE is ignored from here to frame end.
    - First edge after RD_STB: RD_STB=0, RD_DATA captured into the shift register, MDIO_IN_EN=1, MDIO_IN=0 (TA zero bit).
    - Next DATA_W edges: MDIO_IN = RD_DATA bit DATA_W-1 down to 0.
    - Following edge: MDIO_IN_EN=0, MDIO_IN=0, MDIO_DONE=1.
    - Next edge: MDIO_DONE=0, IDLE.
  - SKIP: counts REG_AW+2+DATA_W further edges with no outputs changing, then IDLE. No strobes, no FRAME_ERR.
- Sampling gaps: in PRE/ST/OP/PHYAD/REGAD/WR_TA/WR_DATA, an edge with MDIO_OE=0 is a gap. The counter holds, the bit is not sampled, and there is no abort.
- Read latency: RD_STB to RD_DATA capture is exactly 1 MDC cycle. RD_DATA is sampled only on that edge.
- ADDR and WR_DATA hold their last values between frames.
- Each new frame starts with preamble counter 0. PRE_LEN=0 accepts ST immediately from IDLE on the first sampled 0.
- WR_STB, RD_STB, MDIO_DONE, FRAME_ERR are never high for more than 1 cycle and are mutually exclusive.

Test Plan:
- Write, defaults: 32 ones, then 01 01 00001 00101 10, DATA 0xBEEF -> ADDR=5, WR_DATA=0xBEEF, WR_STB one cycle at the last data edge, MDIO_DONE the next cycle, MDIO_IN_EN stays 0.
- Read: 32 ones, 01 10 00001 00011, RD_DATA=0xA5C3 returned the cycle after RD_STB -> ADDR=3, RD_STB one cycle, MDIO_IN=0 then 1010010111000011, MDIO_IN_EN high 17 cycles, MDIO_DONE after.
- Filtering: read with PHYAD=2 -> no strobes, no MDIO_IN_EN, no DONE, no ERR. Write with PHYAD=0 -> accepted with BCAST_EN=1, skipped with BCAST_EN=0.
- Errors: OP=11 -> FRAME_ERR one cycle after the second OP bit, then IDLE. Write TA=11 with STRICT_TA=1 -> FRAME_ERR and no WR_STB. Preamble of 31 ones before ST -> frame ignored.
- Reset mid-read: assert rst=0 during the data bit-8 edge -> all outputs 0 next edge, no MDIO_DONE. A following legal write completes normally.
- Parametrisation: PRE_LEN=0, DATA_W=8, REG_AW=3, write DATA 0x3C to ADDR 6 with no preamble -> WR_DATA=0x3C, ADDR=6, WR_STB one cycle. Also insert 3 MDIO_OE=0 gaps mid-REGAD -> same result.

Source files
------------

// File: rtl/mdio_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mdio_slave_fsm
// Brief    : Clause 22 MDIO PHY-side slave. Decodes station frames, strobes
//            the register bank and serialises read data back to the station.
// Revision : 1.0
// ============================================================================
module mdio_slave_fsm #(
  parameter logic [4:0] PHY_ADDR  = 5'd1,
  parameter bit         BCAST_EN  = 1'b1,
  parameter int         PRE_LEN   = 32,
  parameter int         REG_AW    = 5,
  parameter int         DATA_W    = 16,
  parameter bit         STRICT_TA = 1'b1
) (
  input  logic              MDC,
  input  logic              rst,
  input  logic              MDIO_OE,
  input  logic              MDIO_OUT,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic              MDIO_IN,
  output logic              MDIO_IN_EN,
  output logic [REG_AW-1:0] ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              WR_STB,
  output logic              RD_STB,
  output logic              MDIO_DONE,
  output logic              FRAME_ERR
);

  // One shift register serves PHYAD, REGAD and DATA, so it must fit the widest.
  localparam int MAX_AD = (DATA_W > REG_AW) ? DATA_W : REG_AW;
  localparam int SRW    = (MAX_AD > 5) ? MAX_AD : 5;
  localparam int SKIP_N = REG_AW + 2 + DATA_W;
  localparam int CW     = $clog2(SKIP_N + 1);

  localparam logic [CW-1:0] PHY_LAST  = CW'(4);
  localparam logic [CW-1:0] REG_LAST  = CW'(REG_AW - 1);
  localparam logic [CW-1:0] DAT_LAST  = CW'(DATA_W - 1);
  localparam logic [CW-1:0] SKIP_LAST = CW'(SKIP_N - 1);
  localparam logic [5:0]    PRE_MAX   = 6'(PRE_LEN);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_ST   = 4'd1,
    S_OP   = 4'd2,
    S_PHY  = 4'd3,
    S_REG  = 4'd4,
    S_WTA  = 4'd5,
    S_WDAT = 4'd6,
    S_WEND = 4'd7,
    S_RTA  = 4'd8,
    S_RDAT = 4'd9,
    S_REND = 4'd10,
    S_DONE = 4'd11,
    S_SKIP = 4'd12
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        pre_q, pre_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SRW-1:0]    sr_q, sr_d;
  logic              first_q, first_d;
  logic              op_wr_q, op_wr_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              in_q, in_d;
  logic              in_en_q, in_en_d;
  logic              wr_stb_q, wr_stb_d;
  logic              rd_stb_q, rd_stb_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [SRW-1:0]    w_shift;
  logic [4:0]        w_phy;
  logic              w_match;

  assign w_shift = {sr_q[SRW-2:0], MDIO_OUT};
  assign w_phy   = w_shift[4:0];
  assign w_match = (w_phy == PHY_ADDR) || (BCAST_EN && (w_phy == 5'd0) && op_wr_q);

  always_ff @(posedge MDC) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      cnt_q    <= '0;
      sr_q     <= '0;
      first_q  <= 1'b0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      in_q     <= 1'b0;
      in_en_q  <= 1'b0;
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      first_q  <= first_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      in_q     <= in_d;
      in_en_q  <= in_en_d;
      wr_stb_q <= wr_stb_d;
      rd_stb_q <= rd_stb_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    first_d  = first_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    in_d     = in_q;
    in_en_d  = in_en_q;
    wr_stb_d = 1'b0;
    rd_stb_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (MDIO_OE) begin
          if (MDIO_OUT) begin
            if (pre_q != PRE_MAX) pre_d = pre_q + 1'b1;
          end else if (pre_q == PRE_MAX) begin
            pre_d   = '0;
            state_d = S_ST;
          end else begin
            pre_d = '0;
          end
        end
      end
      S_ST: begin
        if (MDIO_OE) begin
          if (MDIO_OUT) begin
            cnt_d   = '0;
            state_d = S_OP;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_OP: begin
        if (MDIO_OE) begin
          if (cnt_q == '0) begin
            first_d = MDIO_OUT;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            case ({first_q, MDIO_OUT})
              2'b01: begin op_wr_d = 1'b1; state_d = S_PHY; end
              2'b10: begin op_wr_d = 1'b0; state_d = S_PHY; end
              default: begin err_d = 1'b1; state_d = S_IDLE; end
            endcase
          end
        end
      end
      S_PHY: begin
        if (MDIO_OE) begin
          sr_d = w_shift;
          if (cnt_q == PHY_LAST) begin
            cnt_d   = '0;
            state_d = w_match ? S_REG : S_SKIP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_REG: begin
        if (MDIO_OE) begin
          sr_d = w_shift;
          if (cnt_q == REG_LAST) begin
            cnt_d  = '0;
            addr_d = w_shift[REG_AW-1:0];
            if (op_wr_q) begin
              state_d = S_WTA;
            end else begin
              rd_stb_d = 1'b1;
              state_d  = S_RTA;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WTA: begin
        if (MDIO_OE) begin
          if (cnt_q == '0) begin
            first_d = MDIO_OUT;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (STRICT_TA && ({first_q, MDIO_OUT} != 2'b10)) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WDAT;
            end
          end
        end
      end
      S_WDAT: begin
        if (MDIO_OE) begin
          sr_d = w_shift;
          if (cnt_q == DAT_LAST) begin
            cnt_d    = '0;
            wdata_d  = w_shift[DATA_W-1:0];
            wr_stb_d = 1'b1;
            state_d  = S_WEND;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WEND: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      // Bank answers one cycle after RD_STB; this edge drives the TA zero bit.
      S_RTA: begin
        sr_d    = SRW'(RD_DATA);
        in_en_d = 1'b1;
        in_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_RDAT;
      end
      S_RDAT: begin
        in_d = sr_q[DATA_W-1];
        sr_d = sr_q << 1;
        if (cnt_q == DAT_LAST) begin
          cnt_d   = '0;
          state_d = S_REND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REND: begin
        in_en_d = 1'b0;
        in_d    = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_SKIP: begin
        if (cnt_q == SKIP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign MDIO_IN    = in_q;
  assign MDIO_IN_EN = in_en_q;
  assign ADDR       = addr_q;
  assign WR_DATA    = wdata_q;
  assign WR_STB     = wr_stb_q;
  assign RD_STB     = rd_stb_q;
  assign MDIO_DONE  = done_q;
  assign FRAME_ERR  = err_q;

endmodule
`default_nettype wire
